cus19_crypto_engine: RTL and testbench

Iterative 19-bit block cipher coprocessor. It is the responder side of the special-application (S-type) interface driven by the CPU control unit. The control unit raises start_in and mode_enc_dec_in; this block latches operands, runs one round per clock, returns the result with a done pulse, and holds busy so the pipeline can stall. It sits beside the ALU in the execute stage; the result goes to the write-back mux.

---
 rtl/cus19_crypto_pkg.sv | 28 ++
 rtl/cus19_crypto_round.sv | 26 ++
 rtl/cus19_crypto_engine.sv | 121 ++++++++++++
 tb/tb_cus19_crypto_engine.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cus19_crypto_pkg.sv
// Shared definitions for the cus19 iterative 19-bit block cipher: widths, rotate amounts,
// FSM states and the 19-bit circular rotate helpers.
package cus19_crypto_pkg;

    localparam int DATA_W = 19;
    localparam logic [4:0] ROT_DATA = 5'd3;
    localparam logic [4:0] ROT_KEY  = 5'd5;

    typedef logic [DATA_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // amt is 0..19; doubling the word makes the rotate a plain shift of the upper half.
    function automatic word_t rotl19(input word_t x, input logic [4:0] amt);
        logic [2*DATA_W-1:0] t;
        t = {x, x} << amt;
        return t[2*DATA_W-1:DATA_W];
    endfunction

    function automatic word_t rotr19(input word_t x, input logic [4:0] amt);
        return rotl19(x, 5'(DATA_W) - amt);
    endfunction

endpackage

// File: rtl/cus19_crypto_round.sv
// One cipher round, encrypt or decrypt, including the round-key schedule.
// Purely combinational; the caller supplies the already-mapped round index.
module cus19_crypto_round
    import cus19_crypto_pkg::*;
(
    input  word_t      x_in,
    input  word_t      key_in,
    input  logic [3:0] idx_in,
    input  logic       dec_in,
    output word_t      x_out
);

    logic [4:0] key_rot;
    word_t      round_key;

    always_comb begin
        key_rot   = 5'((int'(ROT_KEY) * int'(idx_in)) % DATA_W);
        round_key = rotl19(key_in, key_rot) ^ word_t'(idx_in);
        if (dec_in) begin
            x_out = rotr19(x_in - round_key, ROT_DATA) ^ round_key;
        end else begin
            x_out = rotl19(x_in ^ round_key, ROT_DATA) + round_key;
        end
    end

endmodule

// File: rtl/cus19_crypto_engine.sv
// S-type cipher coprocessor: latches operands on start, runs one round per clock, pulses done.
// Build option CUS19_CRYPTO_ERR_EN adds a sticky err_out flag for starts issued while busy.
module cus19_crypto_engine
    import cus19_crypto_pkg::*;
#(
    parameter int ROUNDS = 8
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              start_in,
    input  logic              mode_enc_dec_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] key_in,
    output logic [DATA_W-1:0] result_out,
    output logic              busy_out,
`ifdef CUS19_CRYPTO_ERR_EN
    output logic              err_out,
`endif
    output logic              done_out
);

    localparam logic [3:0] LAST = 4'(ROUNDS - 1);

    state_e     state_q, state_d;
    logic [3:0] r_q, r_d;
    word_t      x_q, x_d;
    word_t      key_q, key_d;
    logic       mode_q, mode_d;
    word_t      result_q, result_d;
    logic [3:0] round_idx;
    word_t      round_x;

    // Decrypt walks the key schedule backwards so it undoes encrypt round by round.
    assign round_idx = mode_q ? (LAST - r_q) : r_q;

    cus19_crypto_round u_round (
        .x_in   (x_q),
        .key_in (key_q),
        .idx_in (round_idx),
        .dec_in (mode_q),
        .x_out  (round_x)
    );

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the case infers a latch.
        state_d  = state_q;
        r_d      = r_q;
        x_d      = x_q;
        key_d    = key_q;
        mode_d   = mode_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (start_in) begin
                    x_d     = data_in;
                    key_d   = key_in;
                    mode_d  = mode_enc_dec_in;
                    r_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                x_d = round_x;
                r_d = r_q + 4'd1;
                // Result is registered on the final round so it is already valid while done is high.
                if (r_q == LAST) begin
                    result_d = round_x;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst_in) begin
            state_q  <= IDLE;
            r_q      <= '0;
            x_q      <= '0;
            key_q    <= '0;
            mode_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            r_q      <= r_d;
            x_q      <= x_d;
            key_q    <= key_d;
            mode_q   <= mode_d;
            result_q <= result_d;
        end
    end

    assign result_out = result_q;
    assign busy_out   = (state_q != IDLE);
    assign done_out   = (state_q == DONE);

`ifdef CUS19_CRYPTO_ERR_EN
    logic err_q, err_d;

    // An accepted start clears the flag; a start while busy sets it.
    always_comb begin
        err_d = err_q;
        if (start_in) begin
            err_d = (state_q != IDLE);
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_out = err_q;
`endif

endmodule

// File: tb/tb_cus19_crypto_engine.sv
// Self-checking bench for cus19_crypto_engine (ROUNDS=8 and ROUNDS=1 instances) against
// an arithmetic reference model of the cipher; err_out checks apply with CUS19_CRYPTO_ERR_EN.
module tb_cus19_crypto_engine;

    localparam int unsigned MASK = 32'h7FFFF;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        start_in, mode_in;
    logic [18:0] data_in, key_in, result_out;
    logic        busy_out, done_out;
    logic        start1, mode1;
    logic [18:0] data1, key1, result1;
    logic        busy1, done1;
`ifdef CUS19_CRYPTO_ERR_EN
    logic        err_out, err1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    cus19_crypto_engine #(.ROUNDS(8)) u_dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .start_in        (start_in),
        .mode_enc_dec_in (mode_in),
        .data_in         (data_in),
        .key_in          (key_in),
        .result_out      (result_out),
        .busy_out        (busy_out),
`ifdef CUS19_CRYPTO_ERR_EN
        .err_out         (err_out),
`endif
        .done_out        (done_out)
    );

    cus19_crypto_engine #(.ROUNDS(1)) u_dut1 (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .start_in        (start1),
        .mode_enc_dec_in (mode1),
        .data_in         (data1),
        .key_in          (key1),
        .result_out      (result1),
        .busy_out        (busy1),
`ifdef CUS19_CRYPTO_ERR_EN
        .err_out         (err1),
`endif
        .done_out        (done1)
    );

    // Reference model: plain integer arithmetic on 19-bit values.
    function automatic int unsigned rl(input int unsigned x, input int n);
        int s;
        s = n % 19;
        return ((x << s) | (x >> (19 - s))) & MASK;
    endfunction

    function automatic int unsigned rr(input int unsigned x, input int n);
        return rl(x, (19 - (n % 19)) % 19);
    endfunction

    function automatic int unsigned rkey(input int unsigned k, input int i);
        return rl(k, (5 * i) % 19) ^ i;
    endfunction

    function automatic int unsigned model_enc(input int unsigned d, input int unsigned k, input int rounds);
        int unsigned x;
        x = d;
        for (int i = 0; i < rounds; i++) begin
            x = rl(x ^ rkey(k, i), 3);
            x = (x + rkey(k, i)) & MASK;
        end
        return x;
    endfunction

    function automatic int unsigned model_dec(input int unsigned c, input int unsigned k, input int rounds);
        int unsigned x;
        x = c;
        for (int i = rounds - 1; i >= 0; i--) begin
            x = (x - rkey(k, i)) & MASK;
            x = rr(x, 3) ^ rkey(k, i);
        end
        return x;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_done(output logic [18:0] res);
        int n;
        n = 0;
        while (done_out !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check("done_timeout", 32'(done_out), 32'd1);
        res = result_out;
    endtask

    // Issue from IDLE; returns one cycle after done, back in IDLE.
    task automatic do_op(input logic dec, input logic [18:0] d, input logic [18:0] k,
                         output logic [18:0] res);
        start_in = 1'b1;
        mode_in  = dec;
        data_in  = d;
        key_in   = k;
        step();
        start_in = 1'b0;
        data_in  = 19'($urandom);
        key_in   = 19'($urandom);
        mode_in  = ~dec;
        wait_done(res);
        step();
    endtask

    initial begin
        logic [18:0] c, p, d0, k0, d1, k1, res;
        int          n, done_seen;

        rst_in = 1'b1;
        start_in = 1'b0; mode_in = 1'b0; data_in = '0; key_in = '0;
        start1 = 1'b0; mode1 = 1'b0; data1 = '0; key1 = '0;
        #1;
        check("reset_busy", 32'(busy_out), 32'd0);
        check("reset_done", 32'(done_out), 32'd0);
        check("reset_result", 32'(result_out), 32'd0);
        check("reset_busy1", 32'(busy1), 32'd0);
`ifdef CUS19_CRYPTO_ERR_EN
        check("reset_err", 32'(err_out), 32'd0);
`endif
        step();
        step();
        rst_in = 1'b0;
        step();

        // ROUNDS=1 instance: encrypt 1 with key 0
        start1 = 1'b1; data1 = 19'h00001; key1 = 19'h0; mode1 = 1'b0;
        step();
        start1 = 1'b0; data1 = 19'h7FFFF; key1 = 19'h12345;
        check("r1_busy_c1", 32'(busy1), 32'd1);
        check("r1_done_c1", 32'(done1), 32'd0);
        step();
        check("r1_done_c2", 32'(done1), 32'd1);
        check("r1_result", 32'(result1), 32'h00008);
        check("r1_model", 32'(result1), model_enc(1, 0, 1));
        step();
        check("r1_done_c3", 32'(done1), 32'd0);
        check("r1_busy_c3", 32'(busy1), 32'd0);
        check("r1_hold", 32'(result1), 32'h00008);

        // ROUNDS=8 latency and fixed vector
        start_in = 1'b1; mode_in = 1'b0; data_in = 19'h2A5C3; key_in = 19'h1F0F0;
        for (int j = 0; j <= 9; j++) begin
            step();
            if (j == 0) begin
                start_in = 1'b0;
                data_in  = 19'h0;
                key_in   = 19'h0;
            end
            check($sformatf("lat_busy_%0d", j), 32'(busy_out), (j <= 8) ? 32'd1 : 32'd0);
            check($sformatf("lat_done_%0d", j), 32'(done_out), (j == 8) ? 32'd1 : 32'd0);
            if (j >= 8) begin
                check($sformatf("lat_result_%0d", j), 32'(result_out), model_enc(32'h2A5C3, 32'h1F0F0, 8));
            end
        end
        c = result_out;
        do_op(1'b1, c, 19'h1F0F0, p);
        check("fixed_roundtrip", 32'(p), 32'h2A5C3);

        // Random round trips
        for (int i = 0; i < 1000; i++) begin
            d0 = 19'($urandom);
            k0 = 19'($urandom);
            do_op(1'b0, d0, k0, c);
            check("rand_enc", 32'(c), model_enc(32'(d0), 32'(k0), 8));
            do_op(1'b1, c, k0, p);
            check("rand_dec", 32'(p), 32'(d0));
        end

        // start held high, operands churned during RUN
        d0 = 19'($urandom); k0 = 19'($urandom);
        d1 = 19'($urandom); k1 = 19'($urandom);
        start_in = 1'b1; mode_in = 1'b0; data_in = d0; key_in = k0;
        step();
        n = 0;
        while (done_out !== 1'b1 && n < 40) begin
            data_in = 19'($urandom);
            key_in  = 19'($urandom);
            mode_in = 1'($urandom);
            step();
            n++;
        end
        check("held_done", 32'(done_out), 32'd1);
        check("held_first", 32'(result_out), model_enc(32'(d0), 32'(k0), 8));
`ifdef CUS19_CRYPTO_ERR_EN
        check("held_err_set", 32'(err_out), 32'd1);
`endif
        mode_in = 1'b0; data_in = d1; key_in = k1;
        step();
        check("held_idle_busy", 32'(busy_out), 32'd0);
        step();
        check("held_second_busy", 32'(busy_out), 32'd1);
`ifdef CUS19_CRYPTO_ERR_EN
        check("held_err_clr", 32'(err_out), 32'd0);
`endif
        start_in = 1'b0;
        wait_done(res);
        check("held_second", 32'(res), model_enc(32'(d1), 32'(k1), 8));
        step();

        // Collision pulse at r = 2
        d0 = 19'($urandom); k0 = 19'($urandom);
        start_in = 1'b1; mode_in = 1'b0; data_in = d0; key_in = k0;
        step();
        start_in = 1'b0;
        step();
        step();
        start_in = 1'b1; data_in = ~d0; key_in = ~k0; mode_in = 1'b1;
        step();
        start_in = 1'b0;
`ifdef CUS19_CRYPTO_ERR_EN
        check("coll_err_set", 32'(err_out), 32'd1);
`endif
        wait_done(res);
        check("coll_result", 32'(res), model_enc(32'(d0), 32'(k0), 8));
`ifdef CUS19_CRYPTO_ERR_EN
        check("coll_err_done", 32'(err_out), 32'd1);
`endif
        step();
        check("coll_idle", 32'(busy_out), 32'd0);
`ifdef CUS19_CRYPTO_ERR_EN
        check("coll_err_sticky", 32'(err_out), 32'd1);
`endif
        start_in = 1'b1; mode_in = 1'b0; data_in = d1; key_in = k1;
        step();
        start_in = 1'b0;
`ifdef CUS19_CRYPTO_ERR_EN
        check("coll_err_clr", 32'(err_out), 32'd0);
`endif
        wait_done(res);
        check("coll_next", 32'(res), model_enc(32'(d1), 32'(k1), 8));
        step();

        // Reset mid-RUN at r = 3
        start_in = 1'b1; mode_in = 1'b0; data_in = 19'h2A5C3; key_in = 19'h1F0F0;
        step();
        start_in = 1'b0;
        step();
        step();
        step();
        check("mid_busy_pre", 32'(busy_out), 32'd1);
        rst_in = 1'b1;
        #1;
        rst_in = 1'b0;
        #1;
        check("mid_busy", 32'(busy_out), 32'd0);
        check("mid_done", 32'(done_out), 32'd0);
        check("mid_result", 32'(result_out), 32'd0);
        done_seen = 0;
        for (int j = 0; j < 12; j++) begin
            step();
            if (done_out === 1'b1 || busy_out === 1'b1) done_seen++;
        end
        check("mid_no_done", 32'(done_seen), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
